// File: rtl/shift_exec_unit.sv
// Multi-cycle ARM barrel shifter. Produces shifter_operand and
// shifter_carry_out for operand 2, advancing STEP bit positions per cycle,
// with valid/ready handshakes on the request and result sides.
module shift_exec_unit #(
  parameter int unsigned STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  amount,
  input  logic        rrx,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state, state_next;
  op_t         op, op_in;
  logic [5:0]  eff, rem, k;
  logic [31:0] acc, acc_step;
  logic        carry, carry_step, carry_init;
  logic [63:0] wide;

  // Decode the request: operation kind and effective number of bit positions.
  always_comb begin
    op_in = OP_LSL;
    eff   = '0;
    unique case (shift_type)
      2'b00: begin
        op_in = OP_LSL;
        eff   = (amount > 8'd33) ? 6'd33 : amount[5:0];
      end
      2'b01: begin
        op_in = OP_LSR;
        eff   = (amount > 8'd33) ? 6'd33 : amount[5:0];
      end
      2'b10: begin
        op_in = OP_ASR;
        eff   = (amount > 8'd32) ? 6'd32 : amount[5:0];
      end
      default: begin
        if (rrx) begin
          op_in = OP_RRX;
          eff   = 6'd1;
        end else begin
          op_in = OP_ROR;
          eff   = {1'b0, amount[4:0]};
        end
      end
    endcase
    // A nonzero rotate that is a multiple of 32 takes no SHIFT cycle but
    // still reports value[31] as carry; every other zero-length case keeps C.
    carry_init = (op_in == OP_ROR && amount != 8'd0 && eff == 6'd0) ? value[31] : c_in;
  end

  // One SHIFT cycle: move acc by k = min(STEP, rem) and capture the last bit out.
  always_comb begin
    k          = (rem < STEP_W) ? rem : STEP_W;
    wide       = '0;
    acc_step   = acc;
    carry_step = carry;
    unique case (op)
      OP_LSL: begin
        wide       = {32'b0, acc} << k;
        acc_step   = wide[31:0];
        carry_step = wide[32];
      end
      OP_LSR: begin
        wide       = {acc, 32'b0} >> k;
        acc_step   = wide[63:32];
        carry_step = wide[31];
      end
      OP_ASR: begin
        wide       = $signed({acc, 32'b0}) >>> k;
        acc_step   = wide[63:32];
        carry_step = wide[31];
      end
      OP_ROR: begin
        wide       = {acc, acc} >> k;
        acc_step   = wide[31:0];
        carry_step = wide[31];
      end
      default: begin
        // RRX: carry register still holds the latched C flag here.
        acc_step   = {carry, acc[31:1]};
        carry_step = acc[0];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (eff == 6'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (rem <= STEP_W) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch on accept, step while shifting, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      carry <= 1'b0;
      rem   <= '0;
      op    <= OP_LSL;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= value;
            carry <= carry_init;
            rem   <= eff;
            op    <= op_in;
          end
        end
        SHIFT: begin
          acc   <= acc_step;
          carry <= carry_step;
          rem   <= rem - k;
        end
        default: ;
      endcase
    end
  end

  assign result    = acc;
  assign carry_out = carry;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: directed vector table, hand-written
// backpressure and mid-operation reset sequences, and randomized operations
// checked against a one-shot arithmetic reference model. Two instances run
// side by side, one with STEP=8 and one with STEP=1.
module tb_shift_exec_unit;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] value     [2];
  logic [1:0]  shift_type[2];
  logic [7:0]  amount    [2];
  logic        rrx       [2];
  logic        c_in      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] result    [2];
  logic        carry_out [2];

  int checks = 0;
  int errors = 0;
  int unsigned steps [2] = '{8, 1};

  always #5 clk = ~clk;

  shift_exec_unit #(.STEP(8)) u_dut8 (
    .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .value(value[0]), .shift_type(shift_type[0]), .amount(amount[0]), .rrx(rrx[0]),
    .c_in(c_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .carry_out(carry_out[0])
  );

  shift_exec_unit #(.STEP(1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .value(value[1]), .shift_type(shift_type[1]), .amount(amount[1]), .rrx(rrx[1]),
    .c_in(c_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .carry_out(carry_out[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the architectural shifter_operand/carry computed in one step.
  function automatic logic [32:0] ref_shift(input logic [31:0] v, input logic [1:0] t,
                                            input logic [7:0] a, input logic r, input logic c);
    int n;
    int rr;
    logic [31:0] res;
    logic co;
    n = int'(a);
    rr = int'(a[4:0]);
    res = v;
    co = c;
    if (t == 2'd3 && r) begin
      res = {c, v[31:1]};
      co = v[0];
    end else if (n == 0) begin
      res = v;
      co = c;
    end else begin
      case (t)
        2'd0: begin
          if (n < 32)       begin res = v << n; co = v[32 - n]; end
          else if (n == 32) begin res = '0; co = v[0]; end
          else              begin res = '0; co = 1'b0; end
        end
        2'd1: begin
          if (n < 32)       begin res = v >> n; co = v[n - 1]; end
          else if (n == 32) begin res = '0; co = v[31]; end
          else              begin res = '0; co = 1'b0; end
        end
        2'd2: begin
          if (n < 32) begin res = 32'($signed(v) >>> n); co = v[n - 1]; end
          else        begin res = {32{v[31]}}; co = v[31]; end
        end
        default: begin
          if (rr == 0) begin res = v; co = v[31]; end
          else begin res = (v >> rr) | (v << (32 - rr)); co = v[rr - 1]; end
        end
      endcase
    end
    return {co, res};
  endfunction

  function automatic int ref_lat(input logic [1:0] t, input logic [7:0] a,
                                 input logic r, input int unsigned step);
    int e;
    case (t)
      2'd0, 2'd1: e = (a > 33) ? 33 : int'(a);
      2'd2:       e = (a > 32) ? 32 : int'(a);
      default:    e = r ? 1 : int'(a % 32);
    endcase
    return 1 + (e + int'(step) - 1) / int'(step);
  endfunction

  task automatic drive_req(input int d, input logic [31:0] v, input logic [1:0] t,
                           input logic [7:0] a, input logic r, input logic c);
    in_valid[d] = 1'b1;
    value[d] = v;
    shift_type[d] = t;
    amount[d] = a;
    rrx[d] = r;
    c_in[d] = c;
  endtask

  task automatic scramble(input int d);
    in_valid[d] = 1'b0;
    value[d] = $urandom;
    shift_type[d] = 2'($urandom);
    amount[d] = 8'($urandom);
    rrx[d] = 1'($urandom);
    c_in[d] = 1'($urandom);
  endtask

  // Called right after the accept edge: count cycles to out_valid, check result.
  task automatic wait_done(input int d, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_co);
    int lat = 0;
    bit got = 0;
    while (!got && lat < 80) begin
      @(negedge clk);
      lat++;
      if (out_valid[d]) got = 1;
      else chk("busy_in_ready", 32'(in_ready[d]), 32'd0);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", result[d], exp_res);
    chk("carry", 32'(carry_out[d]), 32'(exp_co));
  endtask

  task automatic release_out(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    chk("out_valid_after_ack", 32'(out_valid[d]), 32'd0);
    chk("in_ready_after_ack", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic run_op(input int d, input logic [31:0] v, input logic [1:0] t,
                        input logic [7:0] a, input logic r, input logic c,
                        input logic [31:0] exp_res, input logic exp_co,
                        input int exp_lat, input int hold);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready[d]), 32'd1);
    drive_req(d, v, t, a, r, c);
    @(posedge clk);
    #1;
    scramble(d);
    wait_done(d, exp_lat, exp_res, exp_co);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid[d]), 32'd1);
      chk("hold_result", result[d], exp_res);
    end
    release_out(d);
  endtask

  typedef struct {
    logic [31:0] v;
    logic [1:0]  t;
    logic [7:0]  a;
    logic        r;
    logic        c;
    logic [31:0] res;
    logic        co;
    int          lat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h8000_0001, 2'd0, 8'd1,  1'b0, 1'b0, 32'h0000_0002, 1'b1, 2};
    tbl[1] = '{32'h8000_0000, 2'd2, 8'd40, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 5};
    tbl[2] = '{32'h8000_0000, 2'd1, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5};
    tbl[3] = '{32'h8000_0001, 2'd0, 8'd33, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 6};
    tbl[4] = '{32'h0000_00F1, 2'd3, 8'd4,  1'b0, 1'b1, 32'h1000_000F, 1'b0, 2};
    tbl[5] = '{32'h0000_00F1, 2'd3, 8'd32, 1'b0, 1'b1, 32'h0000_00F1, 1'b0, 1};
    tbl[6] = '{32'h0000_0001, 2'd3, 8'd77, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 2};
    tbl[7] = '{32'h1234_5678, 2'd1, 8'd0,  1'b0, 1'b1, 32'h1234_5678, 1'b1, 1};
    tbl[8] = '{32'h0000_0001, 2'd0, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5};
    tbl[9] = '{32'h4000_0000, 2'd2, 8'd9,  1'b0, 1'b0, 32'h0020_0000, 1'b0, 3};

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      out_ready[d] = 1'b0;
      scramble(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
      chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
      chk("reset_result", result[d], 32'd0);
      chk("reset_carry", 32'(carry_out[d]), 32'd0);
      reset[d] = 1'b0;
    end

    // Directed vectors on the STEP=8 instance.
    for (int i = 0; i < 10; i++)
      run_op(0, tbl[i].v, tbl[i].t, tbl[i].a, tbl[i].r, tbl[i].c,
             tbl[i].res, tbl[i].co, tbl[i].lat, 0);

    // Backpressure: result held for 5 cycles while a second request waits.
    @(negedge clk);
    drive_req(0, 32'h0000_000F, 2'd0, 8'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive_req(0, 32'h8000_0000, 2'd1, 8'd31, 1'b0, 1'b1);
    wait_done(0, 2, 32'h0000_00F0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_result", result[0], 32'h0000_00F0);
      chk("bp_carry", 32'(carry_out[0]), 32'd0);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    release_out(0);
    @(posedge clk);
    #1;
    scramble(0);
    wait_done(0, 5, 32'h0000_0001, 1'b0);
    release_out(0);

    // Reset in the middle of a long shift on the STEP=1 instance.
    @(negedge clk);
    drive_req(1, 32'hFFFF_FFFF, 2'd0, 8'd31, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    scramble(1);
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(out_valid[1]), 32'd0);
    reset[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready[1]), 32'd1);
    chk("midrst_out_valid", 32'(out_valid[1]), 32'd0);
    chk("midrst_result", result[1], 32'd0);
    chk("midrst_carry", 32'(carry_out[1]), 32'd0);
    @(negedge clk);
    reset[1] = 1'b0;
    repeat (35) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid[1]), 32'd0);
    end
    run_op(1, 32'h0000_0003, 2'd0, 8'd31, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 32, 1);

    // Randomized operations against the reference model on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        logic [31:0] v;
        logic [1:0]  t;
        logic [7:0]  a;
        logic        r;
        logic        c;
        logic [32:0] exp;
        v = $urandom;
        t = 2'($urandom);
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
        r = ($urandom_range(0, 3) == 0);
        c = 1'($urandom);
        exp = ref_shift(v, t, a, r, c);
        run_op(d, v, t, a, r, c, exp[31:0], exp[32],
               ref_lat(t, a, r, steps[d]), int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
